// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of a 5-stage LoongArch pipeline.
//
// Holds the pre-IF next-PC selection, the IF valid/PC registers, the
// synchronous inst SRAM read request and a one-entry instruction buffer
// that keeps the fetched word while ID stalls (the SRAM read data is only
// guaranteed for the cycle after the read).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_to_if_bus        {br_taken, br_target[31:0], br_cancle} from ID
//   id_allow_in         ID can accept an instruction this cycle
//   if_to_id_valid      if_to_id_bus carries a valid instruction
//   if_to_id_bus        {inst[31:0], pc[31:0]}
//   inst_sram_*         synchronous instruction SRAM read port
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC           = 32'h1c000000,
    parameter int          IF_TO_ID_BUS_WIDTH = 64,
    parameter int          ID_TO_IF_BUS_WIDTH = 34
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ID_TO_IF_BUS_WIDTH-1:0] id_to_if_bus,
    input  logic                          id_allow_in,
    output logic                          if_to_id_valid,
    output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
    output logic                          inst_sram_en,
    output logic [3:0]                    inst_sram_we,
    output logic [31:0]                   inst_sram_addr,
    output logic [31:0]                   inst_sram_wdata,
    input  logic [31:0]                   inst_sram_rdata
);

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        br_cancle;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allow_in;
    logic [31:0] fs_inst;

    // br_taken is decoded but intentionally unused: only br_cancle redirects,
    // since the target may be stale while ID is held on a load-use hazard.
    assign br_taken  = id_to_if_bus[ID_TO_IF_BUS_WIDTH-1];
    assign br_target = id_to_if_bus[32:1];
    assign br_cancle = id_to_if_bus[0];

    always_comb begin
        seq_pc      = fs_pc_q + 32'd4;
        nextpc      = br_cancle ? br_target : seq_pc;
        to_fs_valid = ~reset;
        fs_ready_go = 1'b1;
        // A cancel always frees IF: the wrong-path instruction is dropped.
        fs_allow_in = ~fs_valid_q | id_allow_in | br_cancle;
        fs_inst     = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
    end

    assign inst_sram_en    = to_fs_valid & fs_allow_in;
    assign inst_sram_we    = 4'b0;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

    // Gated by reset so nothing is presented while reset is held.
    assign if_to_id_valid = fs_valid_q & fs_ready_go & ~br_cancle & ~reset;
    assign if_to_id_bus   = {fs_inst, fs_pc_q};

    always_comb begin
        fs_valid_d       = fs_valid_q;
        fs_pc_d          = fs_pc_q;
        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;
        if (inst_sram_en) begin
            fs_valid_d       = 1'b1;
            fs_pc_d          = nextpc;
            inst_buf_valid_d = 1'b0;
        end else if (br_cancle) begin
            inst_buf_valid_d = 1'b0;
        end else if (fs_valid_q & ~id_allow_in & ~inst_buf_valid_q) begin
            // First stalled cycle: SRAM data is still valid, latch it before
            // the SRAM output may change.
            inst_buf_d       = inst_sram_rdata;
            inst_buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - 32'd4;
            inst_buf_q       <= 32'b0;
            inst_buf_valid_q <= 1'b0;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            inst_buf_q       <= inst_buf_d;
            inst_buf_valid_q <= inst_buf_valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic        clk;
    logic        reset;
    logic [33:0] id_to_if_bus;
    logic        id_allow_in;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    logic        garbage;
    int          total;
    int          passed;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_to_if_bus    (id_to_if_bus),
        .id_allow_in     (id_allow_in),
        .if_to_id_valid  (if_to_id_valid),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: word = addr ^ PAT; when idle and garbage mode is on,
    // the output is scrambled to prove the stage does not rely on it.
    always @(posedge clk) begin
        if (inst_sram_en)
            inst_sram_rdata <= inst_sram_addr ^ PAT;
        else if (garbage)
            inst_sram_rdata <= $urandom ^ 32'h5A5A0000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; id_allow_in = 1'b1; id_to_if_bus = '0; garbage = 1'b0;
        inst_sram_rdata = 32'h0;
        tick(); tick();
        total++;
        if ({if_to_id_valid, inst_sram_en} !== 2'b00)
            $display("FAIL reset_valid_en got=%b exp=00", {if_to_id_valid, inst_sram_en});
        else passed++;
        total++;
        if (inst_sram_addr !== 32'h1c000000)
            $display("FAIL reset_addr got=%h exp=1c000000", inst_sram_addr);
        else passed++;
        total++;
        if ({inst_sram_we, inst_sram_wdata} !== 36'h0)
            $display("FAIL reset_we_wdata got=%h exp=0", {inst_sram_we, inst_sram_wdata});
        else passed++;
    endtask

    task automatic test_stream();
        reset = 1'b0;
        #1;
        total++;
        if ({inst_sram_en, if_to_id_valid, inst_sram_addr} !== {2'b10, 32'h1c000000})
            $display("FAIL stream_first_req got=%b%b %h exp=10 1c000000",
                     inst_sram_en, if_to_id_valid, inst_sram_addr);
        else passed++;
        tick();
        total++;
        if ({if_to_id_valid, if_to_id_bus, inst_sram_addr} !==
            {1'b1, 32'h1c000000 ^ PAT, 32'h1c000000, 32'h1c000004})
            $display("FAIL stream_c1 got=%b %h %h", if_to_id_valid, if_to_id_bus, inst_sram_addr);
        else passed++;
        tick();
        total++;
        if ({if_to_id_valid, if_to_id_bus, inst_sram_addr} !==
            {1'b1, 32'h1c000004 ^ PAT, 32'h1c000004, 32'h1c000008})
            $display("FAIL stream_c2 got=%b %h %h", if_to_id_valid, if_to_id_bus, inst_sram_addr);
        else passed++;
    endtask

    task automatic test_stall();
        // fs_pc = 1c000004 here
        id_allow_in = 1'b0; garbage = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({inst_sram_en, if_to_id_valid, if_to_id_bus} !==
                {2'b01, 32'h1c000004 ^ PAT, 32'h1c000004})
                $display("FAIL stall_hold_%0d got=%b%b %h", i, inst_sram_en, if_to_id_valid, if_to_id_bus);
            else passed++;
            if (i < 2) tick();
        end
        id_allow_in = 1'b1;
        #1;
        total++;
        if ({inst_sram_en, inst_sram_addr} !== {1'b1, 32'h1c000008})
            $display("FAIL stall_release got=%b %h exp=1 1c000008", inst_sram_en, inst_sram_addr);
        else passed++;
        garbage = 1'b0;
        tick();
        total++;
        if (if_to_id_bus !== {32'h1c000008 ^ PAT, 32'h1c000008})
            $display("FAIL stall_after got=%h", if_to_id_bus);
        else passed++;
    endtask

    task automatic test_cancel();
        tick(); // fs_pc = 1c00000c
        id_to_if_bus = {1'b0, 32'h1c000100, 1'b1};
        #1;
        total++;
        if ({if_to_id_valid, inst_sram_en, inst_sram_addr} !== {2'b01, 32'h1c000100})
            $display("FAIL cancel_cycle got=%b%b %h exp=01 1c000100",
                     if_to_id_valid, inst_sram_en, inst_sram_addr);
        else passed++;
        tick();
        id_to_if_bus = '0;
        #1;
        total++;
        if ({if_to_id_valid, if_to_id_bus, inst_sram_addr} !==
            {1'b1, 32'h1c000100 ^ PAT, 32'h1c000100, 32'h1c000104})
            $display("FAIL cancel_target got=%b %h %h", if_to_id_valid, if_to_id_bus, inst_sram_addr);
        else passed++;
    endtask

    task automatic test_taken_no_cancel();
        id_allow_in = 1'b0;
        id_to_if_bus = {1'b1, 32'h1c000200, 1'b0};
        #1;
        total++;
        if ({inst_sram_en, if_to_id_valid, inst_sram_addr} !== {2'b01, 32'h1c000104})
            $display("FAIL taken_nocancel got=%b%b %h exp=01 1c000104",
                     inst_sram_en, if_to_id_valid, inst_sram_addr);
        else passed++;
        tick(); tick();
        total++;
        if ({if_to_id_valid, if_to_id_bus} !== {1'b1, 32'h1c000100 ^ PAT, 32'h1c000100})
            $display("FAIL taken_pc_held got=%b %h", if_to_id_valid, if_to_id_bus);
        else passed++;
        id_to_if_bus = '0; id_allow_in = 1'b1;
        #1;
        total++;
        if ({inst_sram_en, inst_sram_addr} !== {1'b1, 32'h1c000104})
            $display("FAIL taken_release got=%b %h exp=1 1c000104", inst_sram_en, inst_sram_addr);
        else passed++;
        tick(); // fs_pc = 1c000104
    endtask

    task automatic test_cancel_buffered();
        id_allow_in = 1'b0; garbage = 1'b1;
        tick(); tick(); // buffered, SRAM output now scrambled
        total++;
        if (if_to_id_bus !== {32'h1c000104 ^ PAT, 32'h1c000104})
            $display("FAIL cbuf_buffered got=%h", if_to_id_bus);
        else passed++;
        id_to_if_bus = {1'b0, 32'h1c000300, 1'b1}; garbage = 1'b0;
        #1;
        total++;
        if ({if_to_id_valid, inst_sram_en, inst_sram_addr} !== {2'b01, 32'h1c000300})
            $display("FAIL cbuf_cancel got=%b%b %h", if_to_id_valid, inst_sram_en, inst_sram_addr);
        else passed++;
        tick();
        id_to_if_bus = '0;
        #1;
        total++;
        if ({if_to_id_valid, if_to_id_bus} !== {1'b1, 32'h1c000300 ^ PAT, 32'h1c000300})
            $display("FAIL cbuf_target got=%b %h", if_to_id_valid, if_to_id_bus);
        else passed++;
        id_allow_in = 1'b1;
    endtask

    task automatic test_wrap();
        id_to_if_bus = {1'b0, 32'hfffffffc, 1'b1};
        tick();
        id_to_if_bus = '0;
        #1;
        total++;
        if ({if_to_id_bus[31:0], inst_sram_addr} !== {32'hfffffffc, 32'h0})
            $display("FAIL wrap got=%h %h exp=fffffffc 00000000", if_to_id_bus[31:0], inst_sram_addr);
        else passed++;
    endtask

    task automatic test_reset_mid();
        id_to_if_bus = {1'b0, 32'h1c000040, 1'b1};
        tick();
        id_to_if_bus = '0;
        #1;
        total++;
        if ({if_to_id_valid, if_to_id_bus[31:0]} !== {1'b1, 32'h1c000040})
            $display("FAIL rmid_pc got=%b %h exp=1 1c000040", if_to_id_valid, if_to_id_bus[31:0]);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({if_to_id_valid, inst_sram_en} !== 2'b00)
            $display("FAIL rmid_in_reset got=%b exp=00", {if_to_id_valid, inst_sram_en});
        else passed++;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if ({if_to_id_valid, inst_sram_en, inst_sram_addr} !== {2'b01, 32'h1c000000})
            $display("FAIL rmid_restart got=%b%b %h exp=01 1c000000",
                     if_to_id_valid, inst_sram_en, inst_sram_addr);
        else passed++;
        tick();
        total++;
        if ({if_to_id_valid, if_to_id_bus} !== {1'b1, 32'h1c000000 ^ PAT, 32'h1c000000})
            $display("FAIL rmid_first got=%b %h", if_to_id_valid, if_to_id_bus);
        else passed++;
    endtask

    initial begin
        total = 0; passed = 0;
        test_reset();
        test_stream();
        test_stall();
        test_cancel();
        test_taken_no_cancel();
        test_cancel_buffered();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the LoongArch 5-stage pipeline. It is the producer end of the IF/ID interface: it drives if_to_id_bus {inst, pc} and if_to_id_valid, and consumes id_to_if_bus {br_taken, br_target, br_cancle} and id_allow_in. It contains the pre-IF next-PC logic, the IF valid/PC registers, the synchronous inst SRAM request, and a one-entry instruction buffer that holds the fetched word while ID stalls.

Parameters:
RESET_PC, 32'h1c000000, address of the first fetched instruction after reset
IF_TO_ID_BUS_WIDTH, 64, {inst[31:0], pc[31:0]}, with inst in the MSBs
ID_TO_IF_BUS_WIDTH, 34, {br_taken, br_target[31:0], br_cancle}, with br_taken in the MSB

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_to_if_bus  in  34  {br_taken, br_target, br_cancle} from ID
id_allow_in  in  1  ID can accept an instruction this cycle
if_to_id_valid  out  1  if_to_id_bus carries a valid instruction
if_to_id_bus  out  64  {inst, fs_pc}
inst_sram_en  out  1  read enable
inst_sram_we  out  4  tied to 4'b0
inst_sram_addr  out  32  fetch address (nextpc)
inst_sram_wdata  out  32  tied to 32'b0
inst_sram_rdata  in  32  read data; valid in the cycle after an enabled read; holds its value while en=0

Behaviour:
- Single clock domain. Reset is synchronous and active-high; the ports are named clk/reset.
- Registers: fs_valid, fs_pc, inst_buf[31:0], inst_buf_valid.
- Reset values: fs_valid=0, fs_pc=RESET_PC-4, inst_buf_valid=0, inst_buf=0.
- During reset: if_to_id_valid=0, inst_sram_en=0.
- Pre-IF:
  - seq_pc = fs_pc + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - nextpc = br_cancle ? br_target : seq_pc.
  - to_fs_valid = ~reset.
- fs_ready_go = 1.
- fs_allow_in = ~fs_valid | id_allow_in | br_cancle.
- Fetch request:
  - inst_sram_en = to_fs_valid & fs_allow_in.
  - inst_sram_addr = nextpc (combinational).
- Register update on an enabled request: fs_valid<=1, fs_pc<=nextpc, inst_buf_valid<=0.
- Current instruction: fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Instruction buffer: when fs_valid & ~id_allow_in & ~inst_buf_valid & ~br_cancle, capture inst_buf<=inst_sram_rdata and set inst_buf_valid<=1. The buffer is cleared on any new fetch, on br_cancle, and on reset.
- Output: if_to_id_valid = fs_valid & fs_ready_go & ~br_cancle. In the cancel cycle, the wrong-path instruction in IF is never presented.
- Handshake: a transfer occurs when if_to_id_valid & id_allow_in. if_to_id_bus must stay stable while if_to_id_valid=1 and id_allow_in=0.
- Redirect:
  - Only br_cancle redirects. br_taken without br_cancle (ID stalled on load-use) is ignored, because br_target may be stale.
  - On br_cancle: fetch br_target in the same cycle, regardless of id_allow_in. The flushed IF instruction is dropped.
- Latency: 1 cycle from a request to the instruction being visible in IF. A steady stream with no stalls issues one instruction per cycle.
- The first request after reset deasserts has addr = RESET_PC. The first if_to_id_valid follows in the next cycle with pc = RESET_PC.
- Reset mid-stall or mid-redirect: all state returns to reset values in the next cycle and the fetch restarts at RESET_PC.
- br_cancle concurrent with a buffered instruction: the buffer is discarded and the target is fetched.
- A misaligned br_target is passed through unchecked; exceptions are out of scope.

Test Plan:
- Release reset with id_allow_in=1 and memory returning inst=addr ^ 0xA5A5A5A5 -> inst_sram_addr is 1c000000, 1c000004, 1c000008 on consecutive cycles. if_to_id_bus pc follows one cycle later, with inst matching the pattern.
- Hold id_allow_in=0 for 3 cycles while pc=1c000004, with rdata overwritten by garbage after the first cycle -> inst_sram_en=0. if_to_id_bus stays {inst(1c000004), 1c000004}. When id_allow_in=1, the next addr is 1c000008.
- Assert br_cancle=1, br_target=1c000100 with fs_pc=1c00000c -> if_to_id_valid=0 that cycle and addr=1c000100. Next cycle: pc=1c000100 and valid=1.
- Assert br_taken=1, br_cancle=0, br_target=1c000200 while id_allow_in=0 -> no redirect and fs_pc unchanged. Then drop br_taken and raise id_allow_in -> addr = fs_pc+4.
- Assert br_cancle during a buffered stall -> the buffer is cleared and the next presented instruction is the word fetched from br_target.
- Assert reset for 1 cycle in mid-stream with fs_pc=1c000040 -> next cycle if_to_id_valid=0. The following request has addr=1c000000.
